// File: rtl/pipeline_regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_regfile_writeback_pkg
// Purpose : Shared widths and encodings for the write-back / register-file
//           slice: datapath width, register count, result-source encodings
//           and load funct3 encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pipeline_regfile_writeback_pkg;

   localparam int XLEN           = 32;
   localparam int REG_NUM        = 32;
   localparam int REG_AW         = 5;
   localparam int RET_CNT_W_DFLT = 64;

   // Where the W-stage result comes from
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_PCT = 2'b11
   } result_src_e;

   // Load width/sign encodings carried in funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/pipeline_regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_regfile_writeback_if
// Purpose : Bundles the W-stage inputs, the two D-stage read ports and the
//           write-back / retire outputs of the register-file write-back block.
// Ports   : master - pipeline side (drives i_*, observes o_*)
//           slave  - write-back block (observes i_*, drives o_*)
// Rev     : 1.0  initial release
// ============================================================================
interface pipeline_regfile_writeback_if
   import pipeline_regfile_writeback_pkg::*;
#(
   parameter int RET_CNT_W = RET_CNT_W_DFLT
);
   logic                 i_validW;
   logic                 i_ctrl_reg_wr_enW;
   logic [1:0]           i_ctrl_result_srcW;
   logic [2:0]           i_funct3W;
   logic [XLEN-1:0]      i_alu_resultW;
   logic [XLEN-1:0]      i_mem_readdataW;
   logic [XLEN-1:0]      i_PCPlus4W;
   logic [XLEN-1:0]      i_PCTargetW;
   logic [REG_AW-1:0]    i_regfile_rd_addrW;
   logic [REG_AW-1:0]    i_rs1_addrD;
   logic [REG_AW-1:0]    i_rs2_addrD;
   logic [XLEN-1:0]      o_rs1_dataD;
   logic [XLEN-1:0]      o_rs2_dataD;
   logic [XLEN-1:0]      o_wb_dataW;
   logic                 o_wb_enW;
   logic [REG_AW-1:0]    o_wb_rdW;
   logic [RET_CNT_W-1:0] o_instret;

   modport master (
      output i_validW, i_ctrl_reg_wr_enW, i_ctrl_result_srcW, i_funct3W,
             i_alu_resultW, i_mem_readdataW, i_PCPlus4W, i_PCTargetW,
             i_regfile_rd_addrW, i_rs1_addrD, i_rs2_addrD,
      input  o_rs1_dataD, o_rs2_dataD, o_wb_dataW, o_wb_enW, o_wb_rdW,
             o_instret
   );

   modport slave (
      input  i_validW, i_ctrl_reg_wr_enW, i_ctrl_result_srcW, i_funct3W,
             i_alu_resultW, i_mem_readdataW, i_PCPlus4W, i_PCTargetW,
             i_regfile_rd_addrW, i_rs1_addrD, i_rs2_addrD,
      output o_rs1_dataD, o_rs2_dataD, o_wb_dataW, o_wb_enW, o_wb_rdW,
             o_instret
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_regfile_writeback_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_regfile_writeback_load_extend
// Purpose : Extracts a byte/half/word from an aligned memory word and
//           sign- or zero-extends it according to the load funct3.
// Ports   : word_i   - raw aligned memory word
//           off_i    - byte offset within the word
//           funct3_i - load type
//           data_o   - extended load value (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_regfile_writeback_load_extend
   import pipeline_regfile_writeback_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = word_i[{off_i, 3'b000} +: 8];
      // Halfword loads use only off[1]; off[0] is ignored rather than trapped.
      w_half = off_i[1] ? word_i[31:16] : word_i[15:0];
      data_o = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LH:   data_o = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, w_byte};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, w_half};
         F3_LW:   data_o = word_i;
         default: data_o = word_i;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/pipeline_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_regfile_writeback
// Purpose : Consumer end of the MEM/WB register. Selects the W-stage result,
//           commits it to the 32-entry integer register file (x0 = 0), serves
//           two D-stage read ports with write-through bypass and counts
//           retired instructions.
// Ports   : i_clk  - clock, rising edge
//           i_rstn - asynchronous active-low reset
//           bus    - W-stage inputs, D-stage read ports, write-back outputs
//                    and retired-instruction count
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_regfile_writeback
   import pipeline_regfile_writeback_pkg::*;
#(
   parameter int RET_CNT_W = RET_CNT_W_DFLT
)(
   input  logic                          i_clk,
   input  logic                          i_rstn,
   pipeline_regfile_writeback_if.slave   bus
);
   logic [XLEN-1:0]      regs_q [1:REG_NUM-1];
   logic [RET_CNT_W-1:0] instret_q;
   logic [RET_CNT_W-1:0] instret_d;
   logic                 w_wr_en;
   logic [XLEN-1:0]      w_load_data;
   logic [XLEN-1:0]      w_wb_data;
   logic [XLEN-1:0]      w_rs1_data;
   logic [XLEN-1:0]      w_rs2_data;
   logic [REG_AW-1:0]    w_rd;

   assign w_rd    = bus.i_regfile_rd_addrW;
   assign w_wr_en = bus.i_validW & bus.i_ctrl_reg_wr_enW & (w_rd != '0);

   pipeline_regfile_writeback_load_extend u_load_extend (
      .word_i   (bus.i_mem_readdataW),
      .off_i    (bus.i_alu_resultW[1:0]),
      .funct3_i (bus.i_funct3W),
      .data_o   (w_load_data)
   );

   always_comb begin
      w_wb_data = bus.i_alu_resultW;
      case (bus.i_ctrl_result_srcW)
         RES_ALU: w_wb_data = bus.i_alu_resultW;
         RES_MEM: w_wb_data = w_load_data;
         RES_PC4: w_wb_data = bus.i_PCPlus4W;
         RES_PCT: w_wb_data = bus.i_PCTargetW;
         default: w_wb_data = bus.i_alu_resultW;
      endcase
   end

   // Register file; entry 0 does not exist, x0 is synthesised on read.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 1; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else if (w_wr_en) begin
         regs_q[w_rd] <= w_wb_data;
      end
   end

   // Read ports: the value retiring this cycle is forwarded so D never
   // needs a separate W->D hazard path. Reads are forced to 0 while in reset
   // so a W-stage value cannot leak through the bypass.
   always_comb begin
      w_rs1_data = '0;
      if (i_rstn && bus.i_rs1_addrD != '0) begin
         if (w_wr_en && bus.i_rs1_addrD == w_rd) w_rs1_data = w_wb_data;
         else                                     w_rs1_data = regs_q[bus.i_rs1_addrD];
      end
   end

   always_comb begin
      w_rs2_data = '0;
      if (i_rstn && bus.i_rs2_addrD != '0) begin
         if (w_wr_en && bus.i_rs2_addrD == w_rd) w_rs2_data = w_wb_data;
         else                                     w_rs2_data = regs_q[bus.i_rs2_addrD];
      end
   end

   // Every valid W instruction retires, whether or not it writes rd.
   always_comb begin
      instret_d = instret_q;
      if (bus.i_validW) instret_d = instret_q + RET_CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) instret_q <= '0;
      else         instret_q <= instret_d;
   end

   assign bus.o_rs1_dataD = w_rs1_data;
   assign bus.o_rs2_dataD = w_rs2_data;
   assign bus.o_wb_dataW  = w_wb_data;
   assign bus.o_wb_enW    = w_wr_en;
   assign bus.o_wb_rdW    = w_wr_en ? w_rd : '0;
   assign bus.o_instret   = instret_q;
endmodule
`default_nettype wire
